// File: rtl/rsa_engine_arbiter.sv
// Round-robin arbiter sharing one RSA engine among NUM_REQ requesters; results return to the issuer.
// Optional WAIT watchdog is compiled in with `define RSA_ARB_TIMEOUT_EN.
module rsa_engine_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 256,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_msg_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [DATA_W-1:0]         eng_msg_o,
  output logic                      eng_start_o,
  input  logic                      eng_done_i,
  input  logic [DATA_W-1:0]         eng_data_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic                      busy_o,
  output logic [ID_W-1:0]           grant_id_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("rsa_engine_arbiter: illegal parameter combination");
  end

  logic [1:0]          state_q, state_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   eng_msg_q, eng_msg_d;
  logic                eng_start_q, eng_start_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0]         cnt_q, cnt_d;
`endif

  logic                hi_found;
  logic [ID_W-1:0]     hi_idx, lo_idx, win_idx;
  logic [NUM_REQ-1:0]  win_oh, grant_oh;
  logic [DATA_W-1:0]   msg_sel;
  logic                grant_ready;

  // Winner is the lowest requester above last_grant, else the lowest requester overall.
  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        lo_idx = ID_W'(j);
        if (j > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(j);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_oh   = '0;
    grant_oh = '0;
    msg_sel  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      win_oh[j]   = (win_idx == ID_W'(j));
      grant_oh[j] = (grant_id_q == ID_W'(j));
      if (win_idx == ID_W'(j)) begin
        msg_sel = req_msg_i[j*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_ready = |(rsp_ready_i & grant_oh);

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    eng_start_d  = 1'b0;
    eng_msg_d    = eng_msg_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
`ifdef RSA_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          ack_d      = win_oh;
          eng_msg_d  = msg_sel;
          grant_id_d = win_idx;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_start_d = 1'b1;
        state_d     = ST_WAIT;
`ifdef RSA_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      ST_WAIT: begin
        // A completion always beats a watchdog expiry in the same cycle.
        if (eng_done_i) begin
          rsp_data_d  = eng_data_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = grant_oh;
          state_d     = ST_RESP;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        else if (cnt_q + 32'd1 == 32'(TIMEOUT_CYC)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = grant_oh;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      ST_RESP: begin
        if (grant_ready) begin
          rsp_valid_d  = '0;
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      ack_q        <= '0;
      eng_msg_q    <= '0;
      eng_start_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      eng_msg_q    <= eng_msg_d;
      eng_start_q  <= eng_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign ack_o       = ack_q;
  assign eng_msg_o   = eng_msg_q;
  assign eng_start_o = eng_start_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Randomized and directed bench for rsa_engine_arbiter against a job-level reference model.
module tb_rsa_engine_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 256;
  localparam int ID_W    = 2;
  localparam int TO_CYC  = 16;

  typedef logic [DATA_W-1:0] word_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_msg;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         eng_msg;
  logic                      eng_start;
  logic                      eng_done;
  logic [DATA_W-1:0]         eng_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  always #5 clk = ~clk;

  rsa_engine_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_msg_i(req_msg), .ack_o(ack),
    .eng_msg_o(eng_msg), .eng_start_o(eng_start), .eng_done_i(eng_done), .eng_data_i(eng_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .rsp_ready_i(rsp_ready), .busy_o(busy), .grant_id_o(grant_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one job record from acceptance until its result is consumed.
  int    m_last, m_grant, m_ack_edge, edge_n;
  bit    m_open, m_have, m_err;
  word_t m_msg, m_rsp;
  int    eng_cnt, eng_lat, start_cnt;
  bit    eng_auto, eng_fixed;
  int    acks[$];

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (r[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic step();
    logic                      p_reset, p_done;
    logic [NUM_REQ-1:0]        p_req, p_ready, exp_ack, exp_valid;
    logic [NUM_REQ*DATA_W-1:0] p_msg;
    word_t                     p_data;
    logic                      exp_start;
    int                        w;
    p_reset = reset; p_done = eng_done; p_req = req; p_ready = rsp_ready;
    p_msg = req_msg; p_data = eng_data;
    @(posedge clk);
    #1;
    edge_n++;
    exp_ack = '0;
    exp_start = 1'b0;
    if (p_reset) begin
      m_open = 0; m_have = 0; m_err = 0; m_rsp = '0; m_msg = '0;
      m_last = NUM_REQ - 1; m_grant = 0;
    end else if (m_open && m_have) begin
      if (p_ready[m_grant]) begin
        m_open = 0; m_have = 0; m_last = m_grant;
      end
    end else if (m_open && edge_n == m_ack_edge + 1) begin
      exp_start = 1'b1;
    end else if (m_open) begin
      if (p_done) begin
        m_have = 1; m_rsp = p_data; m_err = 0;
      end
`ifdef RSA_ARB_TIMEOUT_EN
      else if (edge_n - (m_ack_edge + 1) == TO_CYC) begin
        m_have = 1; m_rsp = '0; m_err = 1;
      end
`endif
    end else begin
      w = rr_pick(p_req, m_last);
      if (w >= 0) begin
        m_open = 1; m_grant = w; m_ack_edge = edge_n;
        m_msg = p_msg[w*DATA_W +: DATA_W];
        exp_ack = NUM_REQ'(1) << w;
        acks.push_back(w);
      end
    end
    exp_valid = m_have ? (NUM_REQ'(1) << m_grant) : '0;
    check("ack", word_t'(ack), word_t'(exp_ack));
    check("eng_start", word_t'(eng_start), word_t'(exp_start));
    check("rsp_valid", word_t'(rsp_valid), word_t'(exp_valid));
    check("busy", word_t'(busy), word_t'(m_open));
    check("grant_id", word_t'(grant_id), word_t'(m_grant));
    check("eng_msg", eng_msg, m_msg);
    check("rsp_err", word_t'(rsp_err), word_t'(m_err));
    if (m_have || p_reset) check("rsp_data", rsp_data, m_rsp);
    if (eng_start) start_cnt++;
    // Engine model: answers eng_lat cycles after each start pulse.
    eng_done = 1'b0;
    if (eng_start && eng_auto) eng_cnt = eng_lat;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_data = eng_fixed ? word_t'(256'hABCD) : rand_word();
      end
    end
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int n);
    n = 0;
    while (rsp_valid == '0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_seen"}, word_t'(rsp_valid != '0), word_t'(1'b1));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    req = '0;
    rsp_ready = '1;
    n = 0;
    while ((busy || m_open) && n < 40) begin
      step();
      n++;
    end
    check("drain_idle", word_t'(busy), word_t'(1'b0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0;
    word_t d;
    reset = 1'b1; req = '0; req_msg = '0; eng_done = 1'b0; eng_data = '0; rsp_ready = '0;
    edge_n = 0; eng_cnt = 0; eng_lat = 1; start_cnt = 0; eng_auto = 1; eng_fixed = 0;
    m_last = NUM_REQ - 1; m_grant = 0; m_open = 0; m_have = 0; m_err = 0; m_msg = '0; m_rsp = '0;

    // Reset with all requests pending: nothing may be granted or started.
    req = 4'b1111;
    do_reset(3);
    check("rst_ack", word_t'(ack), '0);
    check("rst_start", word_t'(eng_start), '0);
    req = '0;
    step();

    // Single job from requester 2 with a 10-cycle engine.
    req = 4'b0100;
    req_msg[2*DATA_W +: DATA_W] = word_t'(256'h1234);
    eng_fixed = 1; eng_lat = 10;
    step();
    check("t2_ack", word_t'(ack), word_t'(4'b0100));
    check("t2_gid", word_t'(grant_id), word_t'(2));
    req = '0;
    step();
    check("t2_start", word_t'(eng_start), word_t'(1'b1));
    check("t2_msg", eng_msg, word_t'(256'h1234));
    wait_rsp("t2", 20, n);
    check("t2_lat", word_t'(n), word_t'(10));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_v", word_t'(rsp_valid), word_t'(4'b0100));
      check("t2_hold_d", rsp_data, word_t'(256'hABCD));
    end
    rsp_ready = 4'b0100;
    step();
    check("t2_release", word_t'(rsp_valid), '0);
    eng_fixed = 0;
    drain();

    // Round robin from reset with everyone requesting and ready.
    do_reset(2);
    acks.delete();
    s0 = start_cnt;
    req = 4'b1111; rsp_ready = 4'b1111; eng_lat = 1;
    n = 0;
    while (acks.size() < 5 && n < 60) begin
      step();
      n++;
    end
    step();
    check("rr_jobs", word_t'(acks.size()), word_t'(5));
    for (int i = 0; i < acks.size() && i < 5; i++) check("rr_order", word_t'(acks[i]), word_t'(i % NUM_REQ));
    check("rr_starts", word_t'(start_cnt - s0), word_t'(5));
    drain();

    // Backpressure: result held, other ready bits ignored, no new grant.
    req = 4'b0011; rsp_ready = '0; eng_lat = 3;
    wait_rsp("bp", 20, n);
    req = 4'b0011;
    d = m_rsp;
    for (int i = 0; i < 20; i++) begin
      rsp_ready = (i < 10) ? 4'b0000 : ~(NUM_REQ'(1) << m_grant);
      step();
      check("bp_valid", word_t'(rsp_valid), word_t'(NUM_REQ'(1) << m_grant));
      check("bp_data", rsp_data, d);
      check("bp_noack", word_t'(ack), '0);
    end
    rsp_ready = NUM_REQ'(1) << m_grant;
    step();
    check("bp_release", word_t'(rsp_valid), '0);
    drain();

    // Spurious completion while idle.
    eng_auto = 0; eng_cnt = 0;
    eng_done = 1'b1; eng_data = rand_word();
    step();
    check("sp_idle", word_t'(rsp_valid), '0);
    // Completion coinciding with the ISSUE cycle is ignored.
    req = 4'b0001; rsp_ready = '0;
    step();
    req = '0;
    eng_done = 1'b1; eng_data = rand_word();
    step();
    step();
    check("sp_issue", word_t'(rsp_valid), '0);
    eng_done = 1'b1; eng_data = rand_word();
    step();
    check("sp_real", word_t'(rsp_valid), word_t'(4'b0001));
    rsp_ready = 4'b0001;
    step();
    drain();
    // Reset during WAIT; the engine answer arrives later while idle.
    eng_auto = 1; eng_lat = 5; rsp_ready = '0;
    req = 4'b0100;
    step();
    req = '0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("rst_drop_v", word_t'(rsp_valid), '0);
    check("rst_drop_b", word_t'(busy), '0);

`ifdef RSA_ARB_TIMEOUT_EN
    // Watchdog expiry, then completion racing the expiry.
    eng_auto = 0; eng_cnt = 0;
    for (int t = 0; t < 2; t++) begin
      req = 4'b0010; rsp_ready = '0;
      step();
      req = '0;
      step();
      for (int i = 0; i < TO_CYC - 1; i++) step();
      check("to_early", word_t'(rsp_valid), '0);
      if (t == 1) begin
        eng_done = 1'b1; eng_data = word_t'(256'h5A5A);
      end
      step();
      check("to_valid", word_t'(rsp_valid), word_t'(4'b0010));
      check("to_err", word_t'(rsp_err), word_t'(t == 0));
      check("to_data", rsp_data, (t == 0) ? '0 : word_t'(256'h5A5A));
      rsp_ready = 4'b0010;
      step();
    end
    eng_auto = 1;
    drain();
`endif

    // Randomized traffic against the model.
    eng_auto = 1; eng_fixed = 0; req = '0;
    for (int c = 0; c < 500; c++) begin
      eng_lat = $urandom_range(1, 8);
      rsp_ready = NUM_REQ'($urandom());
      step();
      req = req & ~ack;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_msg[i*DATA_W +: DATA_W] = rand_word();
        end else if (req[i] && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
